// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC mux select
// codes, default widths and the priority decode of the select.
package pc_sequencer_pkg;

  typedef logic [2:0] pc_sel_t;

  // Select codes for the external 5:1 next-PC mux
  localparam pc_sel_t PC_SEL_INC = 3'b000;  // data0: pc + 1
  localparam pc_sel_t PC_SEL_TGT = 3'b001;  // data1: branch/call target
  localparam pc_sel_t PC_SEL_STK = 3'b010;  // data2: return-address stack top
  localparam pc_sel_t PC_SEL_INT = 3'b011;  // data3: interrupt vector
  localparam pc_sel_t PC_SEL_RST = 3'b100;  // data4: reset vector

  localparam int ADDR_W_DEF      = 12;
  localparam int STACK_DEPTH_DEF = 16;

  // Priority-ordered select decode; only codes 000..100 can come out.
  function automatic pc_sel_t decode_sel(input logic rst,
                                         input logic int_take,
                                         input logic stk_take,
                                         input logic tgt_take);
    if (rst)
      return PC_SEL_RST;
    else if (int_take)
      return PC_SEL_INT;
    else if (stk_take)
      return PC_SEL_STK;
    else if (tgt_take)
      return PC_SEL_TGT;
    else
      return PC_SEL_INC;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between instruction decode / next-PC mux and the PC sequencer.
// master = decode + mux side, slave = the sequencer itself.
interface pc_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              en;
  logic              jump;
  logic              call;
  logic              ret;
  logic              reti;
  logic              cond_ok;
  logic [ADDR_W-1:0] target;
  logic              int_req;
  logic [ADDR_W-1:0] pc_next_in;
  logic [2:0]        mux_sel;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pc;
  logic              int_ack;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_err;

  modport master (
    output en, jump, call, ret, reti, cond_ok, target, int_req, pc_next_in,
    input  mux_sel, pc_inc, stack_top, pc, int_ack, stack_empty, stack_full,
           stack_err
  );

  modport slave (
    input  en, jump, call, ret, reti, cond_ok, target, int_req, pc_next_in,
    output mux_sel, pc_inc, stack_top, pc, int_ack, stack_empty, stack_full,
           stack_err
  );
endinterface

// File: rtl/pc_stack_lifo.sv
// Return-address LIFO. Register array with a fill pointer; the top entry is
// read combinationally so it can feed the next-PC mux in the same cycle.
// Push on full and pop on empty are ignored here (pointer held); the caller
// flags them as errors. When empty the top reads as EMPTY_VAL.
module pc_stack_lifo #(
  parameter int                ADDR_W      = 12,
  parameter int                STACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] EMPTY_VAL   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);
  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     top_idx;

  assign empty   = (ptr_reg == '0);
  assign full    = (ptr_reg == PW'(STACK_DEPTH));
  assign top_idx = ptr_reg - PW'(1);

  // Combinational top-of-stack read
  always_comb begin
    top = EMPTY_VAL;
    if (!empty)
      top = mem[top_idx[IW-1:0]];
  end

  // Entry storage: write only when there is room
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[ptr_reg[IW-1:0]] <= data_in;
  end

  // Fill pointer; push and pop are mutually exclusive at the caller
  always_ff @(posedge clk) begin
    if (reset)
      ptr_reg <= '0;
    else if (push && !full)
      ptr_reg <= ptr_reg + PW'(1);
    else if (pop && !empty)
      ptr_reg <= ptr_reg - PW'(1);
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer in front of the 5:1 next-PC mux. Decodes
// interrupt/return/jump/call into the mux select, supplies pc+1 and the
// return-stack top as mux data, and registers the mux result as the PC.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] INT_VEC     = ADDR_W'(12'hFF0)
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  logic [ADDR_W-1:0] pc_reg;
  logic              int_en_reg;
  logic              int_ack_reg;
  logic              stack_err_reg;

  logic              take_int;
  logic              take_pop;
  logic              take_call;
  logic              take_tgt;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] pc_inc;
  logic              lifo_empty;
  logic              lifo_full;

  assign pc_inc = pc_reg + ADDR_W'(1);

  // Priority decode: interrupt > return > jump/call > sequential.
  // A taken interrupt drops any branch in the same cycle.
  always_comb begin
    take_int  = bus.int_req & int_en_reg;
    take_pop  = ~take_int & (bus.reti | (bus.ret & bus.cond_ok));
    take_tgt  = ~take_int & ~take_pop & (bus.jump | bus.call) & bus.cond_ok;
    take_call = take_tgt & bus.call;
    push      = bus.en & ~reset & (take_int | take_call);
    pop       = bus.en & ~reset & take_pop;
    // Interrupt saves the current pc so the interrupted instruction reruns
    push_data = take_int ? pc_reg : pc_inc;
  end

  pc_stack_lifo #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .EMPTY_VAL   (RESET_VEC)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .data_in (push_data),
    .top     (bus.stack_top),
    .empty   (lifo_empty),
    .full    (lifo_full)
  );

  // Program counter: loads the mux result each enabled cycle
  always_ff @(posedge clk) begin
    if (reset)
      pc_reg <= RESET_VEC;
    else if (bus.en)
      pc_reg <= bus.pc_next_in;
  end

  // Interrupt enable and one-cycle acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      int_en_reg  <= 1'b1;
      int_ack_reg <= 1'b0;
    end else begin
      int_ack_reg <= bus.en & take_int;
      if (bus.en) begin
        if (take_int)
          int_en_reg <= 1'b0;
        else if (take_pop && bus.reti)
          int_en_reg <= 1'b1;
      end
    end
  end

  // Sticky stack error: overflow or underflow, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)
      stack_err_reg <= 1'b0;
    else if ((push && lifo_full) || (pop && lifo_empty))
      stack_err_reg <= 1'b1;
  end

  assign bus.mux_sel     = decode_sel(reset, take_int, take_pop, take_tgt);
  assign bus.pc_inc      = pc_inc;
  assign bus.pc          = pc_reg;
  assign bus.int_ack     = int_ack_reg;
  assign bus.stack_empty = lifo_empty;
  assign bus.stack_full  = lifo_full;
  assign bus.stack_err   = stack_err_reg;
endmodule
